// File: rtl/rtc_bus_pkg.sv
// -----------------------------------------------------------------------------
// rtc_bus_pkg
// Shared definitions for the RTC bus scheduler:
//   - state_t       : transaction phase encoding (IDLE, ADDR, GAP1, DATA, RECOV)
//   - REQ_*         : requester indices (init sequencer, time/date write,
//                     periodic time read)
//   - DEF_*_LEN     : default phase lengths in clock cycles
//   - id_to_onehot  : requester index -> one-hot grant/done vector
// -----------------------------------------------------------------------------
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    GAP1  = 3'd2,
    DATA  = 3'd3,
    RECOV = 3'd4
  } state_t;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_INIT = 2'd0;
  localparam logic [1:0] REQ_WR   = 2'd1;
  localparam logic [1:0] REQ_RD   = 2'd2;

  localparam int DEF_ADDR_LEN = 24;
  localparam int DEF_GAP_LEN  = 20;
  localparam int DEF_DATA_LEN = 24;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rtc_bus_scheduler_if.sv
// -----------------------------------------------------------------------------
// rtc_bus_scheduler_if
// Request, grant and RTC bus signals of the scheduler.
// Handshake: a requester raises req[i] (with req_wr/addr/data for slot i
// stable) and holds it until it sees the one-cycle gnt[i] pulse, then drops
// it. A req still high when the scheduler is back in IDLE is a new request.
// done[i] pulses once when the granted transaction completes; rd_data is
// valid from that cycle for reads.
//   slave  : the scheduler (drives gnt/done/rd_data/busy/strobes/ad_out/ad_oe)
//   master : requesters plus RTC pin model (drive en/req*/ad_in)
// dbg_state exposes the scheduler FSM state.
// -----------------------------------------------------------------------------
interface rtc_bus_scheduler_if;
  import rtc_bus_pkg::*;

  logic        en;
  logic [2:0]  req;
  logic [2:0]  req_wr;
  logic [23:0] req_addr;
  logic [23:0] req_data;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [7:0]  rd_data;
  logic        busy;
  logic        en_dir;
  logic        en_wr;
  logic        en_rd;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  ad_in;
  state_t      dbg_state;

  modport slave (
    input  en, req, req_wr, req_addr, req_data, ad_in,
    output gnt, done, rd_data, busy, en_dir, en_wr, en_rd, ad_out, ad_oe,
           dbg_state
  );

  modport master (
    output en, req, req_wr, req_addr, req_data, ad_in,
    input  gnt, done, rd_data, busy, en_dir, en_wr, en_rd, ad_out, ad_oe,
           dbg_state
  );

endinterface

// File: rtl/rtc_phase_timer.sv
// -----------------------------------------------------------------------------
// rtc_phase_timer
// Loadable 8-bit down-counter timing one transaction phase.
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : load load_val_i this cycle (takes priority over counting)
//   load_val_i   : phase length minus one
//   count_o      : current count
//   tc_o         : terminal count (count_o == 0), marks the last phase cycle
// The counter stops at zero; a load value of 0 gives a single-cycle phase.
// -----------------------------------------------------------------------------
module rtc_phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] count_o,
  output logic       tc_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign tc_o    = (cnt_q == 8'd0);

endmodule

// File: rtl/rtc_bus_scheduler.sv
// -----------------------------------------------------------------------------
// rtc_bus_scheduler
// Shares the multiplexed RTC address/data bus between three requesters and
// runs each grant as one fixed-phase transaction:
//   ADDR (ADDR_LEN) -> GAP1 (GAP_LEN) -> DATA (DATA_LEN) -> RECOV (GAP_LEN)
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : rtc_bus_scheduler_if.slave (requests, grants, done pulses,
//                read result, bus strobes and drive, FSM state)
// Arbitration (IDLE only): requester 0 always wins; 1 and 2 alternate via
// rr_pref when both request. Every output comes straight from a flop: the
// combinational block computes next-cycle output values from the next state.
// en=0 sends the FSM to IDLE with all strobes off, keeping rr_pref/rd_data.
// -----------------------------------------------------------------------------
module rtc_bus_scheduler
  import rtc_bus_pkg::*;
#(
  parameter int ADDR_LEN = DEF_ADDR_LEN,
  parameter int GAP_LEN  = DEF_GAP_LEN,
  parameter int DATA_LEN = DEF_DATA_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  rtc_bus_scheduler_if.slave    bus
);

  state_t     state_q, state_d;
  logic [1:0] rr_pref_q, rr_pref_d;
  logic [1:0] id_q, id_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       wr_q, wr_d;
  logic [7:0] rd_data_q, rd_data_d;

  logic [2:0] gnt_q, gnt_d;
  logic [2:0] done_q, done_d;
  logic       busy_q, busy_d;
  logic       en_dir_q, en_dir_d;
  logic       en_wr_q, en_wr_d;
  logic       en_rd_q, en_rd_d;
  logic       ad_oe_q, ad_oe_d;
  logic [7:0] ad_out_q, ad_out_d;

  logic       tmr_load;
  logic [7:0] tmr_val;
  logic [7:0] tmr_count;
  logic       tmr_tc;

  logic [1:0] win;
  logic       last_recov_next;
  logic       data_wr_next;

  rtc_phase_timer u_timer (
    .clk        (clk),
    .rst        (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_o    (tmr_count),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d         = state_q;
    rr_pref_d       = rr_pref_q;
    id_d            = id_q;
    addr_d          = addr_q;
    data_d          = data_q;
    wr_d            = wr_q;
    rd_data_d       = rd_data_q;
    gnt_d           = 3'b000;
    tmr_load        = 1'b0;
    tmr_val         = 8'd0;
    win             = REQ_INIT;
    last_recov_next = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req != 3'b000) begin
            if (bus.req[REQ_INIT]) begin
              win = REQ_INIT;
            end else if (bus.req[REQ_WR] && bus.req[REQ_RD]) begin
              win = rr_pref_q;
            end else if (bus.req[REQ_WR]) begin
              win = REQ_WR;
            end else begin
              win = REQ_RD;
            end
            // Only a grant to 1 or 2 moves the round-robin pointer.
            if (win == REQ_WR) begin
              rr_pref_d = REQ_RD;
            end else if (win == REQ_RD) begin
              rr_pref_d = REQ_WR;
            end
            id_d     = win;
            addr_d   = bus.req_addr[8*win +: 8];
            data_d   = bus.req_data[8*win +: 8];
            wr_d     = bus.req_wr[win];
            gnt_d    = id_to_onehot(win);
            state_d  = ADDR;
            tmr_load = 1'b1;
            tmr_val  = 8'(ADDR_LEN - 1);
          end
        end
        ADDR: begin
          if (tmr_tc) begin
            state_d  = GAP1;
            tmr_load = 1'b1;
            tmr_val  = 8'(GAP_LEN - 1);
          end
        end
        GAP1: begin
          if (tmr_tc) begin
            state_d  = DATA;
            tmr_load = 1'b1;
            tmr_val  = 8'(DATA_LEN - 1);
          end
        end
        DATA: begin
          if (tmr_tc) begin
            if (!wr_q) begin
              rd_data_d = bus.ad_in;
            end
            state_d  = RECOV;
            tmr_load = 1'b1;
            tmr_val  = 8'(GAP_LEN - 1);
          end
        end
        RECOV: begin
          if (tmr_tc) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // done is registered, so it must be raised one edge ahead: next cycle is
    // the last RECOV cycle when the count will read 0 there.
    if (state_d == RECOV) begin
      if (state_q == RECOV) begin
        last_recov_next = (tmr_count == 8'd1);
      end else begin
        last_recov_next = (GAP_LEN == 1);
      end
    end

    data_wr_next = (state_d == DATA) && wr_d;
    busy_d       = (state_d != IDLE);
    en_dir_d     = (state_d == ADDR);
    en_wr_d      = data_wr_next;
    en_rd_d      = (state_d == DATA) && !wr_d;
    ad_oe_d      = en_dir_d || data_wr_next;
    ad_out_d     = en_dir_d ? addr_d : (data_wr_next ? data_d : 8'd0);
    done_d       = last_recov_next ? id_to_onehot(id_d) : 3'b000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_pref_q <= REQ_WR;
      id_q      <= 2'd0;
      addr_q    <= 8'd0;
      data_q    <= 8'd0;
      wr_q      <= 1'b0;
      rd_data_q <= 8'd0;
      gnt_q     <= 3'b000;
      done_q    <= 3'b000;
      busy_q    <= 1'b0;
      en_dir_q  <= 1'b0;
      en_wr_q   <= 1'b0;
      en_rd_q   <= 1'b0;
      ad_oe_q   <= 1'b0;
      ad_out_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      rr_pref_q <= rr_pref_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      rd_data_q <= rd_data_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      en_dir_q  <= en_dir_d;
      en_wr_q   <= en_wr_d;
      en_rd_q   <= en_rd_d;
      ad_oe_q   <= ad_oe_d;
      ad_out_q  <= ad_out_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = busy_q;
  assign bus.en_dir    = en_dir_q;
  assign bus.en_wr     = en_wr_q;
  assign bus.en_rd     = en_rd_q;
  assign bus.ad_oe     = ad_oe_q;
  assign bus.ad_out    = ad_out_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_scheduler
// Directed bench for rtc_bus_scheduler with default phase lengths
// (ADDR 24, GAP 20, DATA 24 -> 88-cycle transaction, grants 89 cycles apart).
// Cycle numbering: cycle 1 is the first ADDR cycle (the cycle gnt is seen).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_rtc_bus_scheduler;
  import rtc_bus_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rtc_bus_scheduler_if bus ();

  rtc_bus_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Phase boundaries in cycles after the grant edge.
  localparam int A_END  = 24;
  localparam int D_BEG  = 45;
  localparam int D_END  = 68;
  localparam int T_END  = 88;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, bus.gnt, bus.done, bus.busy, bus.en_dir, bus.en_wr,
            bus.en_rd, bus.ad_oe, bus.ad_out};
  endfunction

  function automatic logic [31:0] exp_outs(input logic [2:0] g, input logic [2:0] dn,
                                           input logic b, input logic dir,
                                           input logic w, input logic r,
                                           input logic oe, input logic [7:0] o);
    return {13'd0, g, dn, b, dir, w, r, oe, o};
  endfunction

  // Caller has raised req[id] in an IDLE cycle. Checks all 88 cycles of the
  // transaction and the IDLE cycle after it.
  task automatic check_txn(input int id, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] adin,
                           input logic [7:0] exp_rd, input string tag);
    logic [2:0] oh;
    logic       in_data;
    oh = 3'b001 << id;
    for (int c = 1; c <= T_END; c++) begin
      tick();
      if (c == 1) bus.req[id] = 1'b0;
      in_data = (c >= D_BEG) && (c <= D_END);
      bus.ad_in = in_data ? adin : 8'h5A;
      check($sformatf("%s_c%0d", tag, c), outs(),
            exp_outs((c == 1) ? oh : 3'b000,
                     (c == T_END) ? oh : 3'b000,
                     1'b1,
                     c <= A_END,
                     wr && in_data,
                     !wr && in_data,
                     (c <= A_END) || (wr && in_data),
                     (c <= A_END) ? a : ((wr && in_data) ? d : 8'h00)));
    end
    check($sformatf("%s_rd_data", tag), 32'(bus.rd_data), 32'(exp_rd));
    tick();
    check($sformatf("%s_idle", tag), outs(), 32'd0);
    check($sformatf("%s_idle_state", tag), 32'(bus.dbg_state), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0] g_val [7];
  int         g_cyc [7];
  logic [2:0] e_val [7];
  int         e_cyc [7];
  int         ng;
  int         w;

  initial begin
    e_val = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    e_cyc = '{1, 90, 179, 268, 357, 446, 535};
    for (int i = 0; i < 7; i++) begin
      g_val[i] = 3'b000;
      g_cyc[i] = 0;
    end

    // Clock/reset
    reset        = 1'b1;
    bus.en       = 1'b1;
    bus.req      = 3'b000;
    bus.req_wr   = 3'b000;
    bus.req_addr = 24'h000000;
    bus.req_data = 24'h000000;
    bus.ad_in    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 32'd0);
    check("reset_rd_data", 32'(bus.rd_data), 32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'(IDLE));
    reset = 1'b0;

    // Write from the init sequencer: addr 0x02, data 0x10.
    bus.req_addr = {8'h00, 8'h00, 8'h02};
    bus.req_data = {8'h00, 8'h00, 8'h10};
    bus.req_wr   = 3'b001;
    bus.req      = 3'b001;
    check_txn(0, 1'b1, 8'h02, 8'h10, 8'h00, 8'h00, "t1_wr0");

    // Periodic read: addr 0x21, bus returns 0xA5 during DATA.
    bus.req_addr = {8'h21, 8'h00, 8'h02};
    bus.req_wr   = 3'b001;
    bus.req      = 3'b100;
    check_txn(2, 1'b0, 8'h21, 8'h00, 8'hA5, 8'hA5, "t2_rd2");

    // Requesters 1 and 2 held; requester 0 joins mid-transaction at cycle 300.
    bus.req_wr   = 3'b111;
    bus.req_addr = {8'h22, 8'h12, 8'h02};
    bus.req_data = {8'h66, 8'h55, 8'h44};
    bus.req      = 3'b110;
    ng = 0;
    for (int c = 1; c <= 700 && ng < 7; c++) begin
      tick();
      if (c == 300) bus.req[0] = 1'b1;
      if (bus.gnt != 3'b000) begin
        g_val[ng] = bus.gnt;
        g_cyc[ng] = c;
        ng++;
        if (bus.gnt[0]) bus.req[0] = 1'b0;
      end
    end
    check("t3_num_grants", 32'(ng), 32'd7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t3_gnt%0d_val", i), 32'(g_val[i]), 32'(e_val[i]));
      check($sformatf("t3_gnt%0d_cycle", i), 32'(g_cyc[i]), 32'(e_cyc[i]));
    end
    bus.req = 3'b000;
    w = 0;
    while (bus.busy && w < 200) begin
      tick();
      w++;
    end
    check("t3_drain_busy", 32'(bus.busy), 32'd0);
    check("t3_rd_kept", 32'(bus.rd_data), 32'hA5);

    // Abort a write with en=0 in cycle 50, then re-enable with req held.
    bus.req_addr = {8'h22, 8'h11, 8'h02};
    bus.req_data = {8'h66, 8'h77, 8'h44};
    bus.req_wr   = 3'b111;
    bus.req      = 3'b010;
    tick();
    check("t5_gnt", 32'(bus.gnt), 32'b010);
    for (int c = 2; c <= 50; c++) tick();
    check("t5_wr_c50", 32'(bus.en_wr), 32'd1);
    bus.en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t5_abort_%0d", k), outs(), 32'd0);
    end
    check("t5_abort_state", 32'(bus.dbg_state), 32'(IDLE));
    check("t5_rd_kept", 32'(bus.rd_data), 32'hA5);
    bus.en = 1'b1;
    check_txn(1, 1'b1, 8'h11, 8'h77, 8'h3C, 8'hA5, "t5_reen");

    // Read from requester 1, reset asserted in DATA (cycle 55).
    bus.req_wr = 3'b101;
    bus.req_addr = {8'h22, 8'h33, 8'h02};
    bus.req    = 3'b010;
    for (int c = 1; c <= 55; c++) begin
      tick();
      if (c == 1) bus.req = 3'b000;
    end
    check("t6_in_data", 32'(bus.en_rd), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_reset_outs", outs(), 32'd0);
    check("t6_reset_rd_data", 32'(bus.rd_data), 32'd0);
    check("t6_reset_state", 32'(bus.dbg_state), 32'(IDLE));
    @(posedge clk);
    #1;
    reset   = 1'b0;
    bus.req = 3'b110;
    tick();
    check("t6_rr_after_reset", 32'(bus.gnt), 32'b010);
    bus.req = 3'b000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_scheduler.md
Name: rtc_bus_scheduler

Overview:
- Owns the multiplexed address/data bus of the RTC chip and shares it between three requesters: 0 = init sequencer, 1 = time/date write, 2 = periodic time read.
- Each granted request becomes one bus transaction with fixed phases: address phase (en_dir), hold gap, data phase (en_wr or en_rd), recovery gap.
- Replaces the hard-coded count/case timing in the sequencers; those blocks now only present address/data requests.

Parameters:
- ADDR_LEN, 24, cycles en_dir is high (legal range 1..255)
- GAP_LEN, 20, cycles of each hold/recovery gap, all strobes low (1..255)
- DATA_LEN, 24, cycles en_wr or en_rd is high (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  block enable; low aborts and idles the block
- req  in  3  request per requester, level, held until gnt
- req_wr  in  3  per requester: 1 = write, 0 = read
- req_addr  in  24  packed 3x8 RTC register address, requester i at [8i+7:8i]
- req_data  in  24  packed 3x8 write data
- gnt  out  3  one-cycle one-hot grant pulse
- done  out  3  one-cycle one-hot completion pulse
- rd_data  out  8  last read result
- busy  out  1  transaction in progress
- en_dir  out  1  address strobe to RTC interface
- en_wr  out  1  write strobe
- en_rd  out  1  read strobe
- ad_out  out  8  bus drive value
- ad_oe  out  1  bus output enable
- ad_in  in  8  bus sampled value

Behaviour:
- Reset (async): state IDLE; all outputs 0; rr_pref = 1; latched addr/data/wr/id cleared.
- FSM: IDLE -> ADDR -> GAP1 -> DATA -> RECOV -> IDLE. A phase counter loads on entry and advances on its terminal count.
- Arbitration, IDLE only, at a clock edge with en=1 and req!=0:
  - req[0] always wins.
  - Otherwise between 1 and 2: if only one requests it wins; if both request, rr_pref wins.
  - After granting 1 or 2, rr_pref flips to the other requester.
  - The edge latches addr, data, wr and id; the next cycle is the first ADDR cycle.
- gnt[id] pulses in the first ADDR cycle. Requesters must drop req on seeing gnt; a req still high at IDLE is treated as a new request. A req withdrawn before grant is ignored.
- ADDR (ADDR_LEN cycles): en_dir=1, ad_oe=1, ad_out=addr.
- GAP1 and RECOV (GAP_LEN cycles each): en_dir=en_wr=en_rd=0, ad_out=0, ad_oe=0.
- DATA (DATA_LEN cycles):
  - write: en_wr=1, ad_oe=1, ad_out=data.
  - read: en_rd=1, ad_oe=0, ad_out=0.
- Read capture: rd_data <= ad_in on the last DATA cycle and holds until the next read capture. Writes leave rd_data unchanged.
- done[id] pulses in the last RECOV cycle, after which the block returns to IDLE. rd_data is valid from that cycle onward.
- busy is 1 in every non-IDLE state.
- Timing: transaction length = ADDR_LEN + 2*GAP_LEN + DATA_LEN cycles (88 with defaults). IDLE lasts at least 1 cycle, so back-to-back grants are 89 cycles apart.
- All outputs are registered; no combinational path from req to gnt.
- en=0 at any edge:
  - next state IDLE; all strobes, ad_oe, ad_out, gnt and done go to 0.
  - the aborted transaction gets no done.
  - rr_pref and rd_data are kept.
  - no new grant while en=0.
- Simultaneous req and en falling: en wins, no grant.
- Counter: 8-bit down-counter; a length of 1 gives a single-cycle phase.

Decomposition:
- Package rtc_bus_pkg holds:
  - state encoding (IDLE, ADDR, GAP1, DATA, RECOV)
  - requester index constants (REQ_INIT=0, REQ_WR=1, REQ_RD=2)
  - default phase lengths
- Sub-module rtc_phase_timer: loadable 8-bit down-counter with a terminal-count output, instantiated once.

Test Plan:
- req[0]=1, wr=1, addr=0x02, data=0x10 from IDLE:
  - gnt[0] at cycle 1; en_dir with ad_out=0x02 for cycles 1..24; gaps at 25..44.
  - en_wr with ad_out=0x10 for cycles 45..68; done[0] at cycle 88.
- req[2] read addr=0x21, ad_in=0xA5 during DATA -> en_rd high for 24 cycles, ad_oe=0 throughout DATA, rd_data=0xA5 at done[2].
- req[1] and req[2] held together after reset -> grants in order 1, 2, 1, 2; gnt pulses spaced 89 cycles apart.
- req[1] and req[2] pending, then req[0] raised during a transaction -> next grant goes to 0, then round robin resumes with the preserved rr_pref.
- en dropped in cycle 50 of a write -> next cycle all strobes 0 and busy=0, done never pulses; re-enable with req held -> fresh grant, full 88-cycle transaction.
- reset asserted mid-DATA -> outputs 0 immediately (asynchronous), rd_data=0, rr_pref=1.
